fetch_unit: RTL and testbench

Parametrised instruction fetch stage: program counter, fetch-sequencing FSM, and instruction register. It drives a synchronous program memory with configurable read latency and splits each fetched word into opcode and operand fields. It supports PC load (jump), stall and run/halt control, and reports valid for each new instruction. It sits between the program ROM and the decode/execute stage of the nibble-class processor datapath, generalised to arbitrary widths.

---
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage. It holds the PC, sequences reads from a synchronous
// program memory with MEM_LAT cycles of latency, and latches each word into the IR.
module fetch_unit #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int OP_W    = 4,
  parameter int MEM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     stall,
  input  logic                     load_pc,
  input  logic [ADDR_W-1:0]        pc_in,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  output logic [DATA_W-1:0]        program_byte,
  output logic [OP_W-1:0]          inst,
  output logic [DATA_W-OP_W-1:0]   oprnd,
  output logic                     instr_valid,
  output logic [ADDR_W-1:0]        pc
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_cnt,   w_cnt_nxt;
  logic [ADDR_W-1:0] r_pc,    w_pc_nxt;
  logic [DATA_W-1:0] r_ir,    w_ir_nxt;
  logic              r_vld,   w_vld_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_vld_nxt   = 1'b0;
    if (load_pc) begin
      // A jump drops the in-flight fetch. The IR keeps the last valid instruction.
      w_pc_nxt    = pc_in;
      w_cnt_nxt   = '0;
      w_state_nxt = enable ? ISSUE : IDLE;
    end else if (!stall) begin
      case (r_state)
        IDLE:    if (enable) w_state_nxt = ISSUE;
        ISSUE: begin
          w_cnt_nxt   = LAT_M1;
          w_state_nxt = (MEM_LAT == 1) ? CAPTURE : WAIT;
        end
        WAIT: begin
          w_cnt_nxt = r_cnt - 2'd1;
          if (r_cnt <= 2'd1) w_state_nxt = CAPTURE;
        end
        CAPTURE: begin
          w_ir_nxt    = mem_data;
          w_pc_nxt    = r_pc + 1'b1;
          w_vld_nxt   = 1'b1;
          w_state_nxt = enable ? ISSUE : IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pc    <= '0;
      r_ir    <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_vld   <= w_vld_nxt;
    end
  end

  assign mem_addr     = r_pc;
  assign pc           = r_pc;
  assign program_byte = r_ir;
  assign inst         = r_ir[DATA_W-1 -: OP_W];
  assign oprnd        = r_ir[DATA_W-OP_W-1:0];
  assign instr_valid  = r_vld;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. Two instances (MEM_LAT=1 and MEM_LAT=3) share the same control
// inputs. Each is compared every cycle against a phase-count reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, enable, stall, load_pc;
  logic [11:0] pc_in;

  logic [11:0] addr1, pc1, addr3, pc3;
  logic [7:0]  md1, pb1, md3, pb3;
  logic [3:0]  inst1, op1, inst3, op3;
  logic        v1, v3;

  logic [7:0]  mem [4096];
  logic [7:0]  q3 [3];

  int total = 0;
  int bad   = 0;

  // Reference model state: busy means a fetch is in flight; ph counts cycles since ISSUE.
  int m_pc [2], m_ir [2], m_v [2], m_busy [2], m_ph [2];
  int lat [2] = '{1, 3};

  always #5 clk = ~clk;

  // Synchronous program memories with 1- and 3-cycle read latency.
  always @(posedge clk) begin
    md1   <= mem[addr1];
    q3[0] <= mem[addr3];
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end
  assign md3 = q3[2];

  fetch_unit #(.ADDR_W(12), .DATA_W(8), .OP_W(4), .MEM_LAT(1)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .stall(stall), .load_pc(load_pc),
    .pc_in(pc_in), .mem_addr(addr1), .mem_data(md1), .program_byte(pb1),
    .inst(inst1), .oprnd(op1), .instr_valid(v1), .pc(pc1));

  fetch_unit #(.ADDR_W(12), .DATA_W(8), .OP_W(4), .MEM_LAT(3)) u3 (
    .clk(clk), .reset(reset), .enable(enable), .stall(stall), .load_pc(load_pc),
    .pc_in(pc_in), .mem_addr(addr3), .mem_data(md3), .program_byte(pb3),
    .inst(inst3), .oprnd(op3), .instr_valid(v3), .pc(pc3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int k);
    if (reset) begin
      m_pc[k] = 0; m_ir[k] = 0; m_v[k] = 0; m_busy[k] = 0; m_ph[k] = 0;
    end else if (load_pc) begin
      m_pc[k] = int'(pc_in); m_v[k] = 0; m_busy[k] = int'(enable); m_ph[k] = 0;
    end else if (stall) begin
      m_v[k] = 0;
    end else begin
      m_v[k] = 0;
      if (m_busy[k] == 0) begin
        if (enable) begin m_busy[k] = 1; m_ph[k] = 0; end
      end else if (m_ph[k] == lat[k]) begin
        m_ir[k]   = int'(mem[m_pc[k]]);
        m_pc[k]   = (m_pc[k] + 1) % 4096;
        m_v[k]    = 1;
        m_busy[k] = int'(enable);
        m_ph[k]   = 0;
      end else begin
        m_ph[k]++;
      end
    end
  endtask

  task automatic check_all();
    chk("u1.pc",       pc1,   m_pc[0]);
    chk("u1.mem_addr", addr1, m_pc[0]);
    chk("u1.ir",       pb1,   m_ir[0]);
    chk("u1.inst",     inst1, m_ir[0] >> 4);
    chk("u1.oprnd",    op1,   m_ir[0] & 15);
    chk("u1.valid",    v1,    m_v[0]);
    chk("u3.pc",       pc3,   m_pc[1]);
    chk("u3.mem_addr", addr3, m_pc[1]);
    chk("u3.ir",       pb3,   m_ir[1]);
    chk("u3.inst",     inst3, m_ir[1] >> 4);
    chk("u3.oprnd",    op3,   m_ir[1] & 15);
    chk("u3.valid",    v3,    m_v[1]);
  endtask

  task automatic cycle(input logic rs, input logic en, input logic st, input logic ld,
                       input logic [11:0] pi);
    reset = rs; enable = en; stall = st; load_pc = ld; pc_in = pi;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h0F; mem[3] = 8'hF0;
    reset = 1'b1; enable = 1'b0; stall = 1'b0; load_pc = 1'b0; pc_in = '0;

    // Reset: every output must be zero.
    cycle(1, 0, 0, 0, 12'h0);
    cycle(1, 0, 0, 0, 12'h0);
    chk("reset pc", pc1, 0);
    chk("reset valid", v1, 0);
    cycle(0, 0, 0, 0, 12'h0);

    // Free run for 9 cycles from IDLE.
    for (int i = 0; i < 9; i++) cycle(0, 1, 0, 0, 12'h0);
    chk("u1 pc after 4 fetches", pc1, 4);
    chk("u1 last word", pb1, 8'hF0);
    chk("u3 pc after 2 fetches", pc3, 2);
    chk("u3 last word", pb3, 8'h3C);

    // Jump near the top of the address space while u3 is waiting. PC must wrap.
    cycle(0, 1, 0, 0, 12'h0);
    cycle(0, 1, 0, 1, 12'hFFE);
    chk("jump pc", pc3, 12'hFFE);
    for (int i = 0; i < 14; i++) cycle(0, 1, 0, 0, 12'h0);

    // Hold stall for 3 cycles while u1 is about to capture.
    guard = 0;
    while (!(m_busy[0] == 1 && m_ph[0] == lat[0]) && guard < 10) begin
      cycle(0, 1, 0, 0, 12'h0);
      guard++;
    end
    chk("reach capture within bound", guard < 10, 1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 12'h0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 12'h0);

    // Drop enable while u3 is waiting. The fetch completes and the unit then goes idle.
    guard = 0;
    while (!(m_busy[1] == 1 && m_ph[1] >= 1 && m_ph[1] < lat[1]) && guard < 10) begin
      cycle(0, 1, 0, 0, 12'h0);
      guard++;
    end
    chk("reach wait within bound", guard < 10, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 12'h0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 12'h0);

    // Reset takes priority over a simultaneous load_pc.
    cycle(1, 1, 0, 1, 12'h123);
    chk("reset+load pc", pc3, 0);
    chk("reset+load ir", pb3, 0);
    chk("reset+load valid", v3, 0);

    // Randomised control mix.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(63) == 0), ($urandom_range(9) < 8), ($urandom_range(4) == 0),
            ($urandom_range(15) == 0), 12'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
